// File: rtl/seg7_scan_mux.sv
// Time-multiplexed scan driver for a 4-digit common-anode 7-segment display.
// Each digit owns one slot: a dark guard interval, then a PWM-dimmed drive window.
module seg7_scan_mux #(
   parameter int REFRESH_DIV  = 100000,
   parameter int GUARD_CYCLES = 64,
   parameter int CNT_W        = 17
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [4:0] IN_A,
   input  logic [4:0] IN_B,
   input  logic [4:0] IN_C,
   input  logic [4:0] IN_D,
   input  logic [3:0] BLANK_MASK,
   input  logic [2:0] BRIGHTNESS,
   output logic [3:0] SEG_SELECT,
   output logic [7:0] DEC_OUT,
   output logic [1:0] CUR_DIGIT,
   output logic       FRAME_TICK
);

   localparam int               DRIVE_LEN = REFRESH_DIV - GUARD_CYCLES;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYCLES);

   generate
      if (REFRESH_DIV < 16) begin : g_bad_div
         $error("seg7_scan_mux: REFRESH_DIV must be >= 16");
      end
      if (GUARD_CYCLES < 0 || GUARD_CYCLES >= REFRESH_DIV) begin : g_bad_guard
         $error("seg7_scan_mux: GUARD_CYCLES must lie in 0..REFRESH_DIV-1");
      end
      if (CNT_W < 1 || (longint'(1) << CNT_W) < longint'(REFRESH_DIV)) begin : g_bad_cnt_w
         $error("seg7_scan_mux: CNT_W too narrow for REFRESH_DIV");
      end
   endgenerate

   typedef enum logic {
      GUARD = 1'b0,
      DRIVE = 1'b1
   } state_t;

   state_t state, state_nxt;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] offset;
   logic [1:0]       digit;
   logic             wrap;
   logic             slot_start;

   logic [4:0] code_in;
   logic [4:0] code_l;
   logic       blank_l;
   logic [2:0] bri_l;
   logic [4:0] code_eff;
   logic       blank_eff;
   logic [2:0] bri_eff;

   logic       vld_p0;
   logic [3:0] seg_p1;
   logic [7:0] dec_p1;
   logic       tick_p1;

   // On-length of the lit portion of the drive window, never below one clock.
   function automatic logic [CNT_W-1:0] on_len(input logic [2:0] b);
      logic [CNT_W+3:0] prod;
      logic [CNT_W-1:0] len;
      prod = ((CNT_W+4)'(b) + (CNT_W+4)'(1)) * (CNT_W+4)'(DRIVE_LEN);
      len  = CNT_W'(prod >> 3);
      if (len == '0) begin
         len = CNT_W'(1);
      end
      return len;
   endfunction

   function automatic logic [7:0] seg_decode(input logic [4:0] code);
      logic [6:0] s;
      case (code[3:0])
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      return {~code[4], s};
   endfunction

   assign wrap       = (cnt == CNT_LAST);
   assign slot_start = (cnt == '0);
   assign cnt_inc    = cnt + 1'b1;
   assign offset     = cnt - GUARD_END;

   always_comb begin
      case (digit)
         2'd0:    code_in = IN_A;
         2'd1:    code_in = IN_B;
         2'd2:    code_in = IN_C;
         default: code_in = IN_D;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt   <= '0;
         digit <= 2'd0;
      end else begin
         cnt <= wrap ? '0 : cnt_inc;
         if (wrap) begin
            digit <= digit + 2'd1;
         end
      end
   end

   // Slot inputs are frozen at cnt==0; during that first cycle the live values stand in.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         code_l  <= 5'd0;
         blank_l <= 1'b0;
         bri_l   <= 3'd0;
      end else if (slot_start) begin
         code_l  <= code_in;
         blank_l <= BLANK_MASK[digit];
         bri_l   <= BRIGHTNESS;
      end
   end

   assign code_eff  = slot_start ? code_in           : code_l;
   assign blank_eff = slot_start ? BLANK_MASK[digit] : blank_l;
   assign bri_eff   = slot_start ? BRIGHTNESS        : bri_l;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= GUARD;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      vld_p0    = 1'b0;
      case (state)
         GUARD: begin
            if (!wrap && cnt_inc >= GUARD_END) begin
               state_nxt = DRIVE;
            end
         end
         DRIVE: begin
            if (!blank_eff && offset < on_len(bri_eff)) begin
               vld_p0 = 1'b1;
            end
            if (wrap) begin
               state_nxt = (GUARD_CYCLES == 0) ? DRIVE : GUARD;
            end
         end
         default: state_nxt = GUARD;
      endcase
   end

   // p0 -> p1: registered anode/segment drive, changing together on one edge.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         seg_p1  <= 4'hF;
         dec_p1  <= 8'hFF;
         tick_p1 <= 1'b0;
      end else begin
         seg_p1  <= vld_p0 ? ~(4'b0001 << digit) : 4'hF;
         dec_p1  <= vld_p0 ? seg_decode(code_eff) : 8'hFF;
         tick_p1 <= wrap && (digit == 2'd3);
      end
   end

   assign SEG_SELECT = seg_p1;
   assign DEC_OUT    = dec_p1;
   assign CUR_DIGIT  = digit;
   assign FRAME_TICK = tick_p1;

endmodule
